// File: rtl/sop_pkg.sv
// rtl/sop_pkg.sv - shared types, limits and term helper for the SOP sweep block
`timescale 1ns/1ps
package sop_pkg;

    localparam int IN_MAX   = 8;
    localparam int TERM_MAX = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A product term holds when every cared-for literal agrees with its polarity.
    function automatic logic term_match(input logic [IN_MAX-1:0] x,
                                        input logic [IN_MAX-1:0] care,
                                        input logic [IN_MAX-1:0] val);
        return ((x ^ val) & care) == '0;
    endfunction

endpackage

// File: rtl/sop_truth_sweep_if.sv
// rtl/sop_truth_sweep_if.sv - sweep request/result bundle between controller and evaluator
`timescale 1ns/1ps
interface sop_truth_sweep_if #(
    parameter int N_IN = 4
);
    logic                   start;
    logic                   busy;
    logic                   sweep_vld;
    logic [N_IN-1:0]        sweep_x;
    logic                   sweep_f;
    logic                   done;
    logic [(1<<N_IN)-1:0]   tt;
    logic [N_IN:0]          ones_cnt;

    modport master (
        output start,
        input  busy, sweep_vld, sweep_x, sweep_f, done, tt, ones_cnt
    );

    modport slave (
        input  start,
        output busy, sweep_vld, sweep_x, sweep_f, done, tt, ones_cnt
    );
endinterface

// File: rtl/sop_eval.sv
// rtl/sop_eval.sv - combinational sum-of-products evaluation of one input vector
`timescale 1ns/1ps
module sop_eval
    import sop_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int N_TERM = 4
) (
    input  logic [N_IN-1:0]        x,
    input  logic [N_TERM*N_IN-1:0] care,
    input  logic [N_TERM*N_IN-1:0] val,
    input  logic [N_TERM-1:0]      en,
    output logic                   f
);

    // Zero-extended care bits make the unused upper literals don't-cares.
    always_comb begin
        f = 1'b0;
        for (int t = 0; t < N_TERM; t++) begin
            if (en[t] && term_match(IN_MAX'(x),
                                    IN_MAX'(care[t*N_IN +: N_IN]),
                                    IN_MAX'(val[t*N_IN +: N_IN]))) begin
                f = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sop_truth_sweep.sv
// rtl/sop_truth_sweep.sv - live SOP evaluator plus exhaustive truth-table sweep engine
`timescale 1ns/1ps
module sop_truth_sweep
    import sop_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int N_TERM = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_TERM*N_IN-1:0] cfg_care,
    input  logic [N_TERM*N_IN-1:0] cfg_val,
    input  logic [N_TERM-1:0]      cfg_term_en,
    input  logic [N_IN-1:0]        in_vec,
    output logic                   f_live,
    sop_truth_sweep_if.slave       sw
);

    localparam int TT_W = 1 << N_IN;

    state_t                  state;
    logic [N_IN-1:0]         cnt;
    logic [N_TERM*N_IN-1:0]  sh_care;
    logic [N_TERM*N_IN-1:0]  sh_val;
    logic [N_TERM-1:0]       sh_en;
    logic                    busy_q;
    logic                    vld_q;
    logic                    done_q;
    logic [TT_W-1:0]         tt_q;
    logic [N_IN:0]           ones_q;
    logic                    f_live_c;
    logic                    f_shadow;

    sop_eval #(.N_IN(N_IN), .N_TERM(N_TERM)) u_eval_live (
        .x    (in_vec),
        .care (cfg_care),
        .val  (cfg_val),
        .en   (cfg_term_en),
        .f    (f_live_c)
    );

    sop_eval #(.N_IN(N_IN), .N_TERM(N_TERM)) u_eval_shadow (
        .x    (cnt),
        .care (sh_care),
        .val  (sh_val),
        .en   (sh_en),
        .f    (f_shadow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_live <= 1'b0;
        end else begin
            f_live <= f_live_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            sh_care <= '0;
            sh_val  <= '0;
            sh_en   <= '0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            tt_q    <= '0;
            ones_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (sw.start) begin
                        sh_care <= cfg_care;
                        sh_val  <= cfg_val;
                        sh_en   <= cfg_term_en;
                        tt_q    <= '0;
                        ones_q  <= '0;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        vld_q   <= 1'b1;
                        state   <= SWEEP;
                    end
                end
                SWEEP: begin
                    tt_q[cnt] <= f_shadow;
                    ones_q    <= ones_q + {{N_IN{1'b0}}, f_shadow};
                    // Terminal count is detected on all-ones so the counter never has to wrap.
                    if (cnt == '1) begin
                        vld_q  <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Counter holds its last value in IDLE; gate the sweep outputs so they read 0 outside a sweep.
    assign sw.sweep_vld = vld_q;
    assign sw.sweep_x   = vld_q ? cnt : '0;
    assign sw.sweep_f   = vld_q & f_shadow;
    assign sw.busy      = busy_q;
    assign sw.done      = done_q;
    assign sw.tt        = tt_q;
    assign sw.ones_cnt  = ones_q;

endmodule

// File: tb/tb_sop_truth_sweep.sv
// tb/tb_sop_truth_sweep.sv - scoreboard bench for sop_truth_sweep with N_IN=4, N_TERM=4
`timescale 1ns/1ps
module tb_sop_truth_sweep;

    localparam int N_IN   = 4;
    localparam int N_TERM = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [N_TERM*N_IN-1:0] cfg_care = '0;
    logic [N_TERM*N_IN-1:0] cfg_val = '0;
    logic [N_TERM-1:0]      cfg_term_en = '0;
    logic [N_IN-1:0]        in_vec = '0;
    logic                   f_live;

    sop_truth_sweep_if #(.N_IN(N_IN)) sw ();

    sop_truth_sweep #(.N_IN(N_IN), .N_TERM(N_TERM)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_care    (cfg_care),
        .cfg_val     (cfg_val),
        .cfg_term_en (cfg_term_en),
        .in_vec      (in_vec),
        .f_live      (f_live),
        .sw          (sw)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int vld_cnt  = 0;
    logic [N_IN:0] sweep_q[$];
    logic          live_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Literal-by-literal reference, independent of the mask/xor form used in the design.
    function automatic logic model_f(input logic [N_IN-1:0] x);
        logic r;
        logic hit;
        r = 1'b0;
        for (int t = 0; t < N_TERM; t++) begin
            if (cfg_term_en[t]) begin
                hit = 1'b1;
                for (int b = 0; b < N_IN; b++) begin
                    if (cfg_care[t*N_IN+b] && (x[b] != cfg_val[t*N_IN+b])) hit = 1'b0;
                end
                r = r | hit;
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        logic [N_IN:0] e;
        if (sw.sweep_vld) begin
            vld_cnt++;
            if (sweep_q.size() == 0) begin
                check("sweep_unexpected_vld", 32'd1, 32'd0);
            end else begin
                e = sweep_q.pop_front();
                check("sweep_x", 32'(sw.sweep_x), 32'(e[N_IN:1]));
                check("sweep_f", 32'(sw.sweep_f), 32'(e[0]));
            end
        end
    end

    task automatic set_cfg(input logic [15:0] care, input logic [15:0] val, input logic [3:0] en);
        @(posedge clk);
        #1;
        cfg_care    = care;
        cfg_val     = val;
        cfg_term_en = en;
    endtask

    task automatic push_expected();
        for (int x = 0; x < (1 << N_IN); x++) begin
            sweep_q.push_back({x[N_IN-1:0], model_f(x[N_IN-1:0])});
        end
    endtask

    task automatic pulse_start();
        vld_cnt = 0;
        @(posedge clk);
        #1 sw.start = 1'b1;
        @(posedge clk);
        #1 sw.start = 1'b0;
    endtask

    task automatic wait_vld(input int n);
        int c;
        c = 0;
        while (vld_cnt < n && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("wait_vld_timeout", 32'(vld_cnt >= n), 32'd1);
    endtask

    task automatic wait_done(input string tag, input logic [15:0] exp_tt, input logic [4:0] exp_cnt);
        logic got;
        logic gap;
        got = 1'b0;
        gap = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (sw.done) begin
                got = 1'b1;
                break;
            end
            if (!sw.busy) gap = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_busy_gap"}, 32'(gap), 32'd0);
        check({tag, "_vld_cycles"}, 32'(vld_cnt), 32'd16);
        check({tag, "_busy_at_done"}, 32'(sw.busy), 32'd1);
        check({tag, "_tt"}, 32'(sw.tt), 32'(exp_tt));
        check({tag, "_ones"}, 32'(sw.ones_cnt), 32'(exp_cnt));
        check({tag, "_sb_drained"}, 32'(sweep_q.size()), 32'd0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(sw.done), 32'd0);
        check({tag, "_busy_cleared"}, 32'(sw.busy), 32'd0);
        check({tag, "_tt_hold"}, 32'(sw.tt), 32'(exp_tt));
    endtask

    initial begin
        sw.start = 1'b0;
        #12;
        check("rst_f_live", 32'(f_live), 32'd0);
        check("rst_busy", 32'(sw.busy), 32'd0);
        check("rst_vld", 32'(sw.sweep_vld), 32'd0);
        check("rst_x", 32'(sw.sweep_x), 32'd0);
        check("rst_f", 32'(sw.sweep_f), 32'd0);
        check("rst_done", 32'(sw.done), 32'd0);
        check("rst_tt", 32'(sw.tt), 32'd0);
        check("rst_ones", 32'(sw.ones_cnt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // term0 A & ~B, term1 ~C & D
        set_cfg(16'h003C, 16'h0018, 4'b0011);
        push_expected();
        pulse_start();
        wait_done("basic", 16'h2F22, 5'd7);

        // Live path: f_live follows in_vec with one cycle of latency.
        for (int i = 0; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (live_q.size() != 0) check("f_live", 32'(f_live), 32'(live_q.pop_front()));
            if (i < 16) begin
                in_vec = i[N_IN-1:0];
                live_q.push_back(model_f(in_vec));
            end
        end
        @(posedge clk);
        #1;
        in_vec = 4'd9;
        @(posedge clk);
        #1 check("f_live_const_9", 32'(f_live), 32'd1);

        set_cfg(16'h003C, 16'h0018, 4'b0000);
        push_expected();
        pulse_start();
        wait_done("all_off", 16'h0000, 5'd0);

        set_cfg(16'h0000, 16'h0000, 4'b0100);
        push_expected();
        pulse_start();
        wait_done("const1", 16'hFFFF, 5'd16);

        // Config change and repeated start mid-sweep must neither restart nor alter results.
        set_cfg(16'h003C, 16'h0018, 4'b0011);
        push_expected();
        pulse_start();
        wait_vld(5);
        #1;
        cfg_care = 16'hFFFF;
        sw.start = 1'b1;
        @(posedge clk);
        #1 sw.start = 1'b0;
        wait_done("midcfg", 16'h2F22, 5'd7);
        set_cfg(16'h003C, 16'h0018, 4'b0011);

        // Asynchronous reset in the middle of a sweep.
        push_expected();
        pulse_start();
        wait_vld(8);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(sw.busy), 32'd0);
        check("arst_vld", 32'(sw.sweep_vld), 32'd0);
        check("arst_x", 32'(sw.sweep_x), 32'd0);
        check("arst_tt", 32'(sw.tt), 32'd0);
        check("arst_ones", 32'(sw.ones_cnt), 32'd0);
        check("arst_f_live", 32'(f_live), 32'd0);
        sweep_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        push_expected();
        pulse_start();
        wait_done("post_rst", 16'h2F22, 5'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sop_truth_sweep.md
# sop_truth_sweep

Registered, parametrised sum-of-products evaluator with a built-in exhaustive truth-table sweep engine. It evaluates a programmable N-input SOP function two ways: continuously on a live input vector, and by self-sweeping all 2^N_IN input combinations to capture the full truth table and minterm count. It sits next to our fixed combinational logic-function blocks as their reusable, self-checking replacement.

## Interface
- N_IN, 4, number of function inputs (1..8); in_vec[N_IN-1] is the leftmost literal ("A").
- N_TERM, 4, number of product terms (1..16).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_care  in  N_TERM*N_IN  per-term literal mask; term t occupies bits [t*N_IN +: N_IN]; 1 = literal used.
- cfg_val  in  N_TERM*N_IN  per-term literal polarity; 1 = true literal, 0 = complemented.
- cfg_term_en  in  N_TERM  term enable; a disabled term contributes 0.
- in_vec  in  N_IN  live input vector.
- f_live  out  1  registered F(in_vec).
- start  in  1  single-cycle sweep request.
- busy  out  1  sweep in progress.
- sweep_vld  out  1  sweep_x/sweep_f valid this cycle.
- sweep_x  out  N_IN  current swept input.
- sweep_f  out  1  F(sweep_x).
- done  out  1  one-cycle pulse at sweep completion.
- tt  out  2^N_IN  truth table; bit x = F(x).
- ones_cnt  out  N_IN+1  number of minterms where F = 1.

## Operation
- Term t true iff cfg_term_en[t] and ((x ^ val_t) & care_t) == 0. F = OR of all terms. care_t = 0 with enable set is a constant-1 term.
- Live path: f_live <= F(in_vec) every cycle using live cfg_* inputs; independent of sweep state.
- FSM states IDLE, SWEEP, DONE (package enum).
- IDLE: start = 1 captures cfg_care/cfg_val/cfg_term_en into shadow registers, clears tt and ones_cnt, counter <= 0, -> SWEEP.
- SWEEP: each cycle present sweep_x = counter, sweep_f = F_shadow(counter), sweep_vld = 1; tt[counter] <= sweep_f; ones_cnt += sweep_f. When counter == 2^N_IN-1, -> DONE; else counter increments.
- DONE: done = 1 for one cycle, -> IDLE. tt and ones_cnt hold until next accepted start.
- start while busy or in DONE: ignored (no restart, no queueing).
- cfg_* changes during a sweep: no effect on sweep results; affect f_live immediately.
- ones_cnt is N_IN+1 bits so all-ones function (2^N_IN) does not overflow.
- rst_n low at any time (including mid-sweep): immediate return to IDLE; partial results discarded.

## Timing
- Reset values: f_live 0, busy 0, sweep_vld 0, sweep_x 0, sweep_f 0, done 0, tt 0, ones_cnt 0.
- f_live latency: 1 cycle from in_vec.
- start sampled at edge E0; busy = 1 from E0 through end of DONE cycle.
- sweep_vld high for exactly 2^N_IN consecutive cycles after E0, sweep_x = 0,1,..,2^N_IN-1 in order, no gaps.
- done high the cycle after the last sweep_vld; tt/ones_cnt final and stable in that cycle.
- Earliest next start accepted the cycle after done (back-to-back sweeps: 2^N_IN+2 cycles per sweep).
- Counter is N_IN bits; terminal detection on all-ones, never relies on wrap to 0.

## Structure
- Package sop_pkg: state enum (IDLE/SWEEP/DONE), parameter limits, helper function term_match(x, care, val).
- Sub-module sop_eval (combinational, parameters N_IN/N_TERM): x + cfg -> F; instantiated twice (live cfg, shadow cfg).
- Top holds FSM, counter, shadow config, tt, ones_cnt, output registers.

## Test plan
- N_IN=4, term0 care=1100 val=1000, term1 care=0011 val=0001, others disabled; start -> 16 sweep_vld cycles, done, tt = 16'h2F22, ones_cnt = 7.
- Same cfg, drive in_vec 0..15 one per cycle -> f_live matches tt bit of in_vec one cycle later.
- All terms disabled -> tt = 0, ones_cnt = 0; one term enabled with care = 0 -> tt = 16'hFFFF, ones_cnt = 16.
- Change cfg_care mid-sweep and pulse start at sweep cycle 5 -> results unchanged (16'h2F22, 7), no restart, busy continuous.
- Deassert rst_n at sweep cycle 8 -> all outputs 0 asynchronously; after release, new start yields full correct sweep.
- N_IN=1 and N_IN=8 builds: sweep length 2 and 256 cycles, done timing and ones_cnt width correct.
